alu_share_arbiter: RTL and testbench

// - Shares one combinational execute-stage ALU between two requesters: port 0 (integer pipeline) and port 1 (address-gen/auxiliary unit).
// - Arbitrates, drives ALU operands from the winner, captures ALU_OUT/BRANCH_TAKEN into a single-entry response buffer, returns the result with requester ID and tag.

---
 rtl/alu_share_arbiter_if.sv | 70 +++++++
 rtl/alu_share_arbiter.sv | 147 ++++++++++++++
 tb/tb_alu_share_arbiter.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_if.sv
// Purpose: bundles the two request ports, the ALU operand/result pins and the response port of the ALU share arbiter.
// Latency: none, wiring only; the arbiter adds one cycle from request fire to response valid.
// Backpressure: valid/ready on each request port and on the response port; flush drops the buffered response.
interface alu_share_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 5,
    parameter int TAG_WIDTH  = 4
);
    // Port 0: integer pipeline requester
    logic                  req0_valid;
    logic                  req0_ready;
    logic [DATA_WIDTH-1:0] req0_in1;
    logic [DATA_WIDTH-1:0] req0_in2;
    logic [4:0]            req0_shamt;
    logic [OP_WIDTH-1:0]   req0_op;
    logic [TAG_WIDTH-1:0]  req0_tag;

    // Port 1: address-gen / auxiliary requester
    logic                  req1_valid;
    logic                  req1_ready;
    logic [DATA_WIDTH-1:0] req1_in1;
    logic [DATA_WIDTH-1:0] req1_in2;
    logic [4:0]            req1_shamt;
    logic [OP_WIDTH-1:0]   req1_op;
    logic [TAG_WIDTH-1:0]  req1_tag;

    // Shared combinational ALU
    logic [DATA_WIDTH-1:0] alu_in1;
    logic [DATA_WIDTH-1:0] alu_in2;
    logic [4:0]            alu_shamt;
    logic [OP_WIDTH-1:0]   alu_op;
    logic [DATA_WIDTH-1:0] alu_res;
    logic                  alu_br;

    // Response buffer output
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_id;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_br;
    logic [TAG_WIDTH-1:0]  rsp_tag;

    logic                  flush;

    // Arbiter side
    modport slave (
        input  req0_valid, req0_in1, req0_in2, req0_shamt, req0_op, req0_tag,
        output req0_ready,
        input  req1_valid, req1_in1, req1_in2, req1_shamt, req1_op, req1_tag,
        output req1_ready,
        output alu_in1, alu_in2, alu_shamt, alu_op,
        input  alu_res, alu_br,
        output rsp_valid, rsp_id, rsp_data, rsp_br, rsp_tag,
        input  rsp_ready,
        input  flush
    );

    // Requester / ALU / consumer side
    modport master (
        output req0_valid, req0_in1, req0_in2, req0_shamt, req0_op, req0_tag,
        input  req0_ready,
        output req1_valid, req1_in1, req1_in2, req1_shamt, req1_op, req1_tag,
        input  req1_ready,
        input  alu_in1, alu_in2, alu_shamt, alu_op,
        output alu_res, alu_br,
        input  rsp_valid, rsp_id, rsp_data, rsp_br, rsp_tag,
        output rsp_ready,
        output flush
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Purpose: shares one combinational ALU between two requesters, buffering one result with its port id and tag.
// Latency: 1 cycle from request fire to rsp_valid; one op per cycle when the consumer keeps rsp_ready high.
// Backpressure: request ready drops while the response buffer is full and not being drained, or during flush.
// Build option: define ALU_ARB_FIXED_PRIO_EN for port-0 priority with a port-1 starvation guard
// (STARVE_LIM); without it ties are broken round-robin.
module alu_share_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 5,
    parameter int TAG_WIDTH  = 4,
    parameter int STARVE_LIM = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_share_arbiter_if.slave   bus
);

    localparam logic [OP_WIDTH-1:0] ALU_NOP = '0;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } buf_state_t;

    buf_state_t            state;
    logic                  rsp_id_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic                  rsp_br_q;
    logic [TAG_WIDTH-1:0]  rsp_tag_q;

    logic can_issue;
    logic gnt0;
    logic gnt1;
    logic fire0;
    logic fire1;
    logic fire;
    logic pick1;   // tie-break choice when both ports are valid

`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam int SC_W = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
    localparam logic [SC_W-1:0] SC_LIM = SC_W'(STARVE_LIM);

    logic [SC_W-1:0] starve_cnt;

    // Port 0 wins ties until port 1 has lost STARVE_LIM fires in a row.
    assign pick1 = (starve_cnt == SC_LIM);

    // Count consecutive port-1 losses to port 0; saturates at the limit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (fire1) begin
            starve_cnt <= '0;
        end else if (fire0 && bus.req1_valid && (starve_cnt != SC_LIM)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    logic rr_ptr;
    logic unused_cfg;

    // The round-robin pointer names the port that wins the next tie.
    assign pick1 = rr_ptr;

    // STARVE_LIM only shapes the fixed-priority build.
    assign unused_cfg = ^STARVE_LIM;

    // After a fire the pointer moves to the port that did not win; idle and flush cycles hold it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= 1'b0;
        end else if (fire) begin
            rr_ptr <= fire0;
        end
    end
`endif

    // A new op may issue when the buffer is empty or is being drained this cycle; flush blocks issue.
    assign can_issue = !bus.flush && ((state == ST_EMPTY) || bus.rsp_ready);

    // Grant: a lone valid port wins, a tie goes to the port chosen by pick1.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            gnt1 = pick1;
            gnt0 = !pick1;
        end else begin
            gnt0 = bus.req0_valid;
            gnt1 = bus.req1_valid;
        end
    end

    // Grants are one-hot, so the two ready outputs are never high together.
    assign bus.req0_ready = gnt0 && can_issue;
    assign bus.req1_ready = gnt1 && can_issue;

    assign fire0 = bus.req0_valid && bus.req0_ready;
    assign fire1 = bus.req1_valid && bus.req1_ready;
    assign fire  = fire0 || fire1;

    // Steer the granted port's operands to the ALU; NOP and zero operands when nothing is granted.
    always_comb begin
        bus.alu_in1   = '0;
        bus.alu_in2   = '0;
        bus.alu_shamt = '0;
        bus.alu_op    = ALU_NOP;
        if (gnt1) begin
            bus.alu_in1   = bus.req1_in1;
            bus.alu_in2   = bus.req1_in2;
            bus.alu_shamt = bus.req1_shamt;
            bus.alu_op    = bus.req1_op;
        end else if (gnt0) begin
            bus.alu_in1   = bus.req0_in1;
            bus.alu_in2   = bus.req0_in2;
            bus.alu_shamt = bus.req0_shamt;
            bus.alu_op    = bus.req0_op;
        end
    end

    // Response buffer FSM: capture on fire, drain on rsp_ready, drop on flush; flush beats rsp_ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_EMPTY;
            rsp_id_q   <= 1'b0;
            rsp_data_q <= '0;
            rsp_br_q   <= 1'b0;
            rsp_tag_q  <= '0;
        end else if (bus.flush) begin
            state <= ST_EMPTY;
        end else if (fire) begin
            state      <= ST_FULL;
            rsp_id_q   <= fire1;
            rsp_data_q <= bus.alu_res;
            rsp_br_q   <= bus.alu_br;
            rsp_tag_q  <= fire1 ? bus.req1_tag : bus.req0_tag;
        end else if (bus.rsp_ready) begin
            state <= ST_EMPTY;
        end
    end

    assign bus.rsp_valid = (state == ST_FULL);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_br    = rsp_br_q;
    assign bus.rsp_tag   = rsp_tag_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Purpose: directed bench for alu_share_arbiter with a response scoreboard and a small reference ALU.
// Latency: expects responses one cycle after each request fire.
// Backpressure: exercises held responses, flush, and reset while the buffer is full.
module tb_alu_share_arbiter;

    localparam int DW = 32;
    localparam int OW = 5;
    localparam int TW = 4;

`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam bit FP = 1'b1;
`else
    localparam bit FP = 1'b0;
`endif

    // Port-1 grant pattern per cycle, MSB first, for each build
    localparam logic [5:0]  P2_G1 = FP ? 6'b000111 : 6'b101010;
    localparam logic [12:0] P6_G1 = FP ? 13'b0000100001111 : 13'b1010101010000;

    typedef struct {
        logic [OW-1:0] op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [4:0]    sh;
        logic [TW-1:0] tag;
        logic [DW-1:0] exp_d;
        logic          exp_br;
    } vec_t;

    typedef struct {
        logic          id;
        logic [DW-1:0] d;
        logic          br;
        logic [TW-1:0] tag;
    } rsp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    vec_t q0[$];
    vec_t q1[$];
    rsp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_share_arbiter_if #(.DATA_WIDTH(DW), .OP_WIDTH(OW), .TAG_WIDTH(TW)) bus ();

    alu_share_arbiter #(
        .DATA_WIDTH(DW),
        .OP_WIDTH  (OW),
        .TAG_WIDTH (TW),
        .STARVE_LIM(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Reference ALU: a handful of arithmetic, shift and branch codes
    always_comb begin
        bus.alu_res = '0;
        bus.alu_br  = 1'b0;
        case (bus.alu_op)
            5'd1:    bus.alu_res = bus.alu_in1 + bus.alu_in2;
            5'd2:    bus.alu_res = bus.alu_in1 - bus.alu_in2;
            5'd3:    bus.alu_res = bus.alu_in1 & bus.alu_in2;
            5'd4:    bus.alu_res = bus.alu_in1 | bus.alu_in2;
            5'd5:    bus.alu_res = bus.alu_in1 ^ bus.alu_in2;
            5'd6:    bus.alu_res = bus.alu_in1 << bus.alu_shamt;
            5'd12:   bus.alu_br  = (bus.alu_in1 == bus.alu_in2);
            5'd13:   bus.alu_br  = (bus.alu_in1 != bus.alu_in2);
            default: ;
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int op, input int a, input int b, input int sh,
                                input int tag, input int exp_d, input int exp_br);
        vec_t v;
        v.op     = OW'(op);
        v.a      = DW'(a);
        v.b      = DW'(b);
        v.sh     = 5'(sh);
        v.tag    = TW'(tag);
        v.exp_d  = DW'(exp_d);
        v.exp_br = exp_br != 0;
        return v;
    endfunction

    task automatic drive_ports();
        bus.req0_valid = (q0.size() > 0);
        bus.req1_valid = (q1.size() > 0);
        if (q0.size() > 0) begin
            bus.req0_op = q0[0].op; bus.req0_in1 = q0[0].a; bus.req0_in2 = q0[0].b;
            bus.req0_shamt = q0[0].sh; bus.req0_tag = q0[0].tag;
        end else begin
            bus.req0_op = '0; bus.req0_in1 = '0; bus.req0_in2 = '0;
            bus.req0_shamt = '0; bus.req0_tag = '0;
        end
        if (q1.size() > 0) begin
            bus.req1_op = q1[0].op; bus.req1_in1 = q1[0].a; bus.req1_in2 = q1[0].b;
            bus.req1_shamt = q1[0].sh; bus.req1_tag = q1[0].tag;
        end else begin
            bus.req1_op = '0; bus.req1_in1 = '0; bus.req1_in2 = '0;
            bus.req1_shamt = '0; bus.req1_tag = '0;
        end
    endtask

    // One cycle: present queue heads, check readies (and rsp_valid unless exp_rv < 0),
    // push the expected response of whichever port fires, then step past the edge.
    task automatic run_cycle(input bit e0, input bit e1, input int exp_rv, input string name);
        rsp_t r;
        drive_ports();
        @(negedge clk);
        check({name, "_rdy0"}, 64'(bus.req0_ready), 64'(e0));
        check({name, "_rdy1"}, 64'(bus.req1_ready), 64'(e1));
        if (exp_rv >= 0) check({name, "_rsp_valid"}, 64'(bus.rsp_valid), 64'(exp_rv));
        if (bus.req0_valid && bus.req0_ready) begin
            check({name, "_alu_in1"}, 64'(bus.alu_in1), 64'(q0[0].a));
            check({name, "_alu_op"}, 64'(bus.alu_op), 64'(q0[0].op));
            r.id = 1'b0; r.d = q0[0].exp_d; r.br = q0[0].exp_br; r.tag = q0[0].tag;
            sb.push_back(r);
            q0.delete(0);
        end
        if (bus.req1_valid && bus.req1_ready) begin
            check({name, "_alu_in1"}, 64'(bus.alu_in1), 64'(q1[0].a));
            check({name, "_alu_op"}, 64'(bus.alu_op), 64'(q1[0].op));
            r.id = 1'b1; r.d = q1[0].exp_d; r.br = q1[0].exp_br; r.tag = q1[0].tag;
            sb.push_back(r);
            q1.delete(0);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every consumed response against the scoreboard; a flushed response is dropped.
    always @(negedge clk) begin
        rsp_t e;
        if (rst_n) begin
            if (bus.flush && bus.rsp_valid) begin
                if (sb.size() > 0) sb.delete(0);
            end else if (bus.rsp_valid && bus.rsp_ready) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rsp_unexpected: got id=%0d data=0x%0h tag=%0d, required no response",
                             bus.rsp_id, bus.rsp_data, bus.rsp_tag);
                end else begin
                    e = sb.pop_front();
                    check("rsp_id",   64'(bus.rsp_id),   64'(e.id));
                    check("rsp_data", 64'(bus.rsp_data), 64'(e.d));
                    check("rsp_br",   64'(bus.rsp_br),   64'(e.br));
                    check("rsp_tag",  64'(bus.rsp_tag),  64'(e.tag));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.flush     = 1'b0;
        bus.rsp_ready = 1'b0;
        drive_ports();

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("rst_rsp_data",  64'(bus.rsp_data),  64'(0));
        check("rst_rsp_tag",   64'(bus.rsp_tag),   64'(0));
        check("rst_rsp_id",    64'(bus.rsp_id),    64'(0));
        check("rst_rsp_br",    64'(bus.rsp_br),    64'(0));
        check("rst_alu_op",    64'(bus.alu_op),    64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single op: ADD 7+5 tag 3 on port 0
        bus.rsp_ready = 1'b1;
        q0.push_back(mk(1, 7, 5, 0, 3, 12, 0));
        run_cycle(1'b1, 1'b0, 0, "single");
        run_cycle(1'b0, 1'b0, 1, "single_rsp");

        // Both ports valid, consumer always ready: one grant per cycle
        q0.push_back(mk(1, 10, 100, 0, 1, 110, 0));
        q0.push_back(mk(2, 50, 8, 0, 2, 42, 0));
        q0.push_back(mk(5, 'hF0, 'hFF, 0, 3, 'h0F, 0));
        q1.push_back(mk(3, 'hF0F0, 'hFF00, 0, 4, 'hF000, 0));
        q1.push_back(mk(4, 'h0F, 'hF0, 0, 5, 'hFF, 0));
        q1.push_back(mk(6, 1, 0, 4, 6, 16, 0));
        for (int k = 0; k < 6; k++) begin
            run_cycle(!P2_G1[5-k], P2_G1[5-k], (k == 0) ? 0 : 1, "arb");
        end
        run_cycle(1'b0, 1'b0, 1, "arb_drain");

        // Backpressure: fill, hold three cycles, then release
        bus.rsp_ready = 1'b0;
        q0.push_back(mk(1, 1, 2, 0, 7, 3, 0));
        q1.push_back(mk(1, 3, 4, 0, 8, 7, 0));
        run_cycle(FP, !FP, 0, "bp_fill");
        for (int k = 0; k < 3; k++) begin
            run_cycle(1'b0, 1'b0, 1, "bp_hold");
            check("bp_hold_data", 64'(bus.rsp_data), FP ? 64'd3 : 64'd7);
        end
        bus.rsp_ready = 1'b1;
        run_cycle(!FP, FP, 1, "bp_release");
        run_cycle(1'b0, 1'b0, 1, "bp_drain");
        run_cycle(1'b0, 1'b0, 0, "bp_empty");

        // Branch compares on port 1
        q1.push_back(mk(12, 9, 9, 0, 9, 0, 1));
        q1.push_back(mk(13, 9, 9, 0, 10, 0, 0));
        run_cycle(1'b0, 1'b1, 0, "br_beq");
        run_cycle(1'b0, 1'b1, 1, "br_bne");
        run_cycle(1'b0, 1'b0, 1, "br_drain");
        run_cycle(1'b0, 1'b0, 0, "br_empty");

        // Flush while full with port 0 waiting
        bus.rsp_ready = 1'b0;
        q0.push_back(mk(1, 20, 22, 0, 11, 42, 0));
        q0.push_back(mk(1, 100, 1, 0, 12, 101, 0));
        run_cycle(1'b1, 1'b0, 0, "fl_fill");
        bus.flush = 1'b1;
        run_cycle(1'b0, 1'b0, 1, "fl_flush");
        bus.flush = 1'b0;
        run_cycle(1'b1, 1'b0, 0, "fl_after");
        bus.rsp_ready = 1'b1;
        run_cycle(1'b0, 1'b0, 1, "fl_drain");
        run_cycle(1'b0, 1'b0, 0, "fl_empty");

        // Sustained contention: 8 ops on port 0, 5 on port 1
        for (int i = 0; i < 8; i++) q0.push_back(mk(1, i, 1000, 0, i, i + 1000, 0));
        for (int i = 0; i < 5; i++) q1.push_back(mk(1, i, 2000, 0, i + 8, i + 2000, 0));
        for (int k = 0; k < 13; k++) begin
            run_cycle(!P6_G1[12-k], P6_G1[12-k], (k == 0) ? 0 : 1, "cont");
        end
        run_cycle(1'b0, 1'b0, 1, "cont_drain");

        // Reset with a result sitting in the buffer: it must never be delivered
        bus.rsp_ready = 1'b0;
        q0.push_back(mk(1, 1, 1, 0, 1, 2, 0));
        run_cycle(1'b1, 1'b0, 0, "rst_fill");
        rst_n = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_mid_valid", 64'(bus.rsp_valid), 64'(0));
        check("rst_mid_data",  64'(bus.rsp_data),  64'(0));
        check("rst_mid_tag",   64'(bus.rsp_tag),   64'(0));
        bus.rsp_ready = 1'b1;
        run_cycle(1'b0, 1'b0, 0, "rst_after");

        check("sb_empty", 64'(sb.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
